uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 1, clock cycles per serial bit; legal range 1..65535.
REQ-002 Parameter: STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: resetn  input  1  asynchronous, active-high reset (asserted = 1), despite the name.
REQ-005 Port: data  input  8  byte to transmit; sampled only on an accepting edge.
REQ-006 Port: valid  input  1  data holds a byte to send.
REQ-007 Port: ready  output  1  holding register can accept a byte.
REQ-008 Port: ctrl  input  8  control/status byte passed through to state.
REQ-009 Port: state  output  8  {ctrl[7:4], tx_busy, ctrl[2:0]}.
REQ-010 Port: pin  output  1  serial line; idle high; drives the uart_rx pin input.

Function
REQ-011 Frame: one start bit (0), 8 data bits LSB first, then STOP_BITS stop bits (1); no parity.
REQ-012 Each bit holds on pin for exactly CLKS_PER_BIT cycles, timed by a divider counter reloaded at every bit boundary.
REQ-013 Handshake: a byte is accepted on a rising edge where valid=1 and ready=1; data is copied into a one-entry holding register.
REQ-014 ready = not hold_full (combinational from registered state); valid with ready=0 has no effect; data may change freely while not accepted.
REQ-015 FSM states: IDLE, START, DATA, STOP.
REQ-016 IDLE: pin=1; when hold_full=1, next edge moves hold to the shift register, clears hold_full, enters START.
REQ-017 START: pin=0 for one bit time, then DATA with bit index 0.
REQ-018 DATA: pin = shift[index]; after each bit time index increments; after index 7 completes, enter STOP.
REQ-019 STOP: pin=1 for STOP_BITS bit times; at the end, if hold_full=1, go directly to START (hold to shift, hold_full cleared) with no idle gap; otherwise go to IDLE.
REQ-020 Latency: accept at edge N; pin falls at edge N+1 when FSM is IDLE.
REQ-021 Accept during an active frame fills hold; the active frame is not disturbed.
REQ-022 When hold drains on the same edge that valid=1 arrives, the new byte is not accepted that edge (ready was 0); it is accepted on the following edge.
REQ-023 tx_busy = 1 in START, DATA, STOP or when hold_full=1; 0 otherwise.
REQ-024 pin, ready and tx_busy are glitch-free registered or register-derived; pin is a flop output.
REQ-025 Bit-time counter width is 16 bits; index width is 3 bits; no wrap of index beyond 7.

Reset
REQ-026 While resetn=1: FSM=IDLE, pin=1, hold_full=0, ready=1, tx_busy=0, shift=0, hold=0, counter=0, index=0.
REQ-027 Reset mid-frame takes effect immediately (asynchronous): pin returns high at once, in-flight and held bytes are discarded.
REQ-028 First accept is possible on the first rising edge after resetn deasserts.

Structure
REQ-029 FSM state encodings and the state-byte bit position (TX_BUSY_BIT = 3) belong in the shared UART package, alongside the receiver's RX_DATA_BIT = 2.
REQ-030 One sub-module is natural: uart_baud_cnt (bit-time divider emitting a one-cycle bit_done pulse), reusable by the receiver.

Verification
REQ-031 CLKS_PER_BIT=1, send 0xA5 -> pin after falling edge: 0,1,0,1,0,0,1,0,1,1, then idle 1; looped-back uart_rx data=0xA5.
REQ-032 CLKS_PER_BIT=4, send 0x3C -> each bit held 4 cycles; frame length 40 cycles; start bit falls 1 edge after accept.
REQ-033 Back-to-back: valid held high with 0x01 then 0x80 -> second start bit immediately follows first stop bit; ready low while hold full; no gap cycles.
REQ-034 STOP_BITS=2, send 0xFF -> pin low for one bit, high for 10 bit times; tx_busy clears at end of the second stop bit.
REQ-035 Assert resetn in DATA at index 4 of 0x00 -> pin=1 in the same cycle; ready=1; after release, send 0x5A transmits correctly.
REQ-036 ctrl=0xFF while idle -> state=0xF7; during a frame -> state=0xFF.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding and status-byte bit positions
// used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  localparam int TX_BUSY_BIT = 3;
  localparam int RX_DATA_BIT = 2;

  // Pass ctrl through, replacing the transmitter busy bit.
  function automatic logic [7:0] tx_status_byte(input logic [7:0] ctrl, input logic busy);
    logic [7:0] res;
    res = ctrl;
    res[TX_BUSY_BIT] = busy;
    return res;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-time divider: counts CLKS_PER_BIT cycles while enabled and emits a one-cycle
// bit_done pulse on the last cycle of each bit, restarting from zero.
module uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic bit_done
);

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 32'd1);

  logic [15:0] cnt_r;

  assign bit_done = enable && (cnt_r == LAST);

  // Counter idles at zero and reloads at every bit boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= 16'd0;
    end else if (!enable || bit_done) begin
      cnt_r <= 16'd0;
    end else begin
      cnt_r <= cnt_r + 16'd1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register in front of a start/8N/stop shifter.
// Note: resetn is asynchronous and active-high despite its name.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  input  logic [7:0] ctrl,
  output logic [7:0] state,
  output logic       pin
);

  localparam logic STOP_LAST = (STOP_BITS == 32'd2) ? 1'b1 : 1'b0;

  tx_state_e  fsm_r, fsm_s;
  logic [7:0] hold_r, shift_r, shift_s;
  logic       hold_full_r, hold_full_s;
  logic [2:0] idx_r, idx_s;
  logic       stop_cnt_r, stop_cnt_s;
  logic       pin_r, pin_s;
  logic       bit_done_s, accept_s, load_s, tx_busy_s;

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst      (resetn),
    .enable   (fsm_r != TX_IDLE),
    .bit_done (bit_done_s)
  );

  assign accept_s  = valid && !hold_full_r;
  assign ready     = !hold_full_r;
  assign tx_busy_s = (fsm_r != TX_IDLE) || hold_full_r;
  assign state     = tx_status_byte(ctrl, tx_busy_s);
  assign pin       = pin_r;

  // Next-state logic; pin_s is the line level for the next cycle so pin stays a flop.
  always_comb begin
    fsm_s      = fsm_r;
    shift_s    = shift_r;
    idx_s      = idx_r;
    stop_cnt_s = stop_cnt_r;
    pin_s      = pin_r;
    load_s     = 1'b0;
    case (fsm_r)
      TX_IDLE: begin
        if (hold_full_r) begin
          load_s  = 1'b1;
          shift_s = hold_r;
          fsm_s   = TX_START;
          pin_s   = 1'b0;
        end else begin
          fsm_s = TX_IDLE;
          pin_s = 1'b1;
        end
      end
      TX_START: begin
        if (bit_done_s) begin
          fsm_s = TX_DATA;
          idx_s = 3'd0;
          pin_s = shift_r[0];
        end else begin
          pin_s = 1'b0;
        end
      end
      TX_DATA: begin
        if (bit_done_s) begin
          if (idx_r == 3'd7) begin
            fsm_s      = TX_STOP;
            stop_cnt_s = 1'b0;
            pin_s      = 1'b1;
          end else begin
            idx_s = idx_r + 3'd1;
            pin_s = shift_r[idx_r + 3'd1];
          end
        end else begin
          pin_s = shift_r[idx_r];
        end
      end
      TX_STOP: begin
        if (bit_done_s) begin
          if (stop_cnt_r == STOP_LAST) begin
            // A waiting byte starts immediately, with no idle gap.
            if (hold_full_r) begin
              load_s  = 1'b1;
              shift_s = hold_r;
              fsm_s   = TX_START;
              pin_s   = 1'b0;
            end else begin
              fsm_s = TX_IDLE;
              pin_s = 1'b1;
            end
          end else begin
            stop_cnt_s = stop_cnt_r + 1'b1;
            pin_s      = 1'b1;
          end
        end else begin
          pin_s = 1'b1;
        end
      end
      default: begin
        fsm_s = TX_IDLE;
        pin_s = 1'b1;
      end
    endcase

    if (accept_s) begin
      hold_full_s = 1'b1;
    end else if (load_s) begin
      hold_full_s = 1'b0;
    end else begin
      hold_full_s = hold_full_r;
    end
  end

  // State, datapath and line registers.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      fsm_r       <= TX_IDLE;
      hold_r      <= 8'd0;
      hold_full_r <= 1'b0;
      shift_r     <= 8'd0;
      idx_r       <= 3'd0;
      stop_cnt_r  <= 1'b0;
      pin_r       <= 1'b1;
    end else begin
      fsm_r       <= fsm_s;
      hold_r      <= accept_s ? data : hold_r;
      hold_full_r <= hold_full_s;
      shift_r     <= shift_s;
      idx_r       <= idx_s;
      stop_cnt_r  <= stop_cnt_s;
      pin_r       <= pin_s;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table-driven frames at CLKS_PER_BIT=1 plus
// directed sequences for divider=4, two stop bits, back-to-back and mid-frame reset.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] ctrl;
  logic [7:0] data1, data4, data2;
  logic       valid1, valid4, valid2;
  logic       ready1, ready4, ready2;
  logic [7:0] state1, state4, state2;
  logic       pin1, pin4, pin2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .resetn(resetn), .data(data1), .valid(valid1), .ready(ready1),
    .ctrl(ctrl), .state(state1), .pin(pin1));
  uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut4 (
    .clk(clk), .resetn(resetn), .data(data4), .valid(valid4), .ready(ready4),
    .ctrl(ctrl), .state(state4), .pin(pin4));
  uart_tx #(.CLKS_PER_BIT(1), .STOP_BITS(2)) dut2 (
    .clk(clk), .resetn(resetn), .data(data2), .valid(valid2), .ready(ready2),
    .ctrl(ctrl), .state(state2), .pin(pin2));

  typedef struct {
    logic [7:0] data;
    logic [7:0] ctrl;
    logic [9:0] frame;    // bit k is the k-th bit on the line
    logic [7:0] st_idle;
    logic [7:0] st_busy;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Send one byte on dut1 from idle and check every line bit and the status byte.
  task automatic run_vec(input vec_t v);
    logic [7:0] got;
    got = 8'h00;
    ctrl = v.ctrl;
    #1;
    chk("idle_state", state1, v.st_idle);
    chk("idle_ready", ready1, 1);
    data1  = v.data;
    valid1 = 1'b1;
    @(negedge clk);
    valid1 = 1'b0;
    data1  = ~v.data;
    chk("ready_after_accept", ready1, 0);
    chk("pin_before_start", pin1, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("frame_bit", pin1, v.frame[k]);
      if (k == 0) chk("busy_state", state1, v.st_busy);
      if (k >= 1 && k <= 8) got[k-1] = pin1;
    end
    @(negedge clk);
    chk("pin_idle_after", pin1, 1);
    chk("state_idle_after", state1, v.st_idle);
    chk("loopback_byte", got, v.data);
  endtask

  initial begin
    logic [19:0] b2b;
    logic [9:0]  f4;
    vec_t        v5a;

    vecs[0] = '{data: 8'hA5, ctrl: 8'hFF, frame: 10'h34A, st_idle: 8'hF7, st_busy: 8'hFF};
    vecs[1] = '{data: 8'h3C, ctrl: 8'h00, frame: 10'h278, st_idle: 8'h00, st_busy: 8'h08};
    vecs[2] = '{data: 8'h00, ctrl: 8'h5A, frame: 10'h200, st_idle: 8'h52, st_busy: 8'h5A};
    vecs[3] = '{data: 8'h80, ctrl: 8'hA5, frame: 10'h300, st_idle: 8'hA5, st_busy: 8'hAD};
    v5a     = '{data: 8'h5A, ctrl: 8'h00, frame: 10'h2B4, st_idle: 8'h00, st_busy: 8'h08};

    resetn = 1'b1;
    ctrl   = 8'h00;
    data1  = 8'h00; data4 = 8'h00; data2 = 8'h00;
    valid1 = 1'b0;  valid4 = 1'b0; valid2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pin", pin1, 1);
    chk("rst_ready", ready1, 1);
    chk("rst_state", state1, 8'h00);
    chk("rst_pin4", pin4, 1);
    resetn = 1'b0;

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Back-to-back: valid held high across two bytes.
    data1 = 8'h01; valid1 = 1'b1;
    @(negedge clk);
    chk("b2b_ready_full", ready1, 0);
    chk("b2b_pin_idle", pin1, 1);
    data1 = 8'h80;
    b2b = 20'hC0202;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("b2b_bit", pin1, b2b[k]);
      if (k == 0) chk("b2b_ready_drained", ready1, 1);
      if (k == 1) begin
        chk("b2b_ready_second", ready1, 0);
        valid1 = 1'b0;
      end
      if (k == 9) chk("b2b_ready_held", ready1, 0);
      if (k == 10) chk("b2b_ready_reload", ready1, 1);
    end
    @(negedge clk);
    chk("b2b_idle_pin", pin1, 1);
    chk("b2b_idle_busy", state1[3], 0);

    // Divider of 4: each bit held four cycles, 40-cycle frame.
    ctrl = 8'h00;
    f4 = 10'h278;
    data4 = 8'h3C; valid4 = 1'b1;
    @(negedge clk);
    valid4 = 1'b0;
    chk("div4_ready", ready4, 0);
    chk("div4_pin_before", pin4, 1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk("div4_bit", pin4, f4[k/4]);
    end
    @(negedge clk);
    chk("div4_idle_pin", pin4, 1);
    chk("div4_idle_busy", state4[3], 0);

    // Two stop bits with 0xFF.
    data2 = 8'hFF; valid2 = 1'b1;
    @(negedge clk);
    valid2 = 1'b0;
    chk("stop2_ready", ready2, 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k < 11) chk("stop2_bit", pin2, (k == 0) ? 1'b0 : 1'b1);
      else        chk("stop2_idle_pin", pin2, 1);
      chk("stop2_busy", state2[3], (k <= 10) ? 1'b1 : 1'b0);
    end

    // Reset in DATA at index 4 of 0x00.
    data1 = 8'h00; valid1 = 1'b1;
    @(negedge clk);
    valid1 = 1'b0;
    repeat (5) @(negedge clk);
    @(negedge clk);
    chk("mid_pin_idx4", pin1, 0);
    resetn = 1'b1;
    #1;
    chk("mid_rst_pin", pin1, 1);
    chk("mid_rst_ready", ready1, 1);
    chk("mid_rst_busy", state1[3], 0);
    @(negedge clk);
    resetn = 1'b0;
    run_vec(v5a);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
